// File: rtl/fc_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// fc_hazard_ctrl
//
// Pipeline flow controller. Watches the ID/EX instruction, the register
// indices being read in ID, taken branches/jumps resolved in EX and the
// data-memory handshake. It drives the stall/flush controls of the IF/ID,
// ID/EX and EX/MEM registers and the PC redirect.
//
// Hazards handled, highest priority first:
//   - data-memory wait: the request is not ready in the cycle it is issued,
//     so the whole front of the pipe freezes until ready or timeout
//   - taken branch/jump in EX: redirect the PC and squash IF/ID and ID/EX
//   - load-use: hold PC and IF/ID for one cycle and bubble ID/EX
//
// Parameters:
//   MEM_TIMEOUT  cycles waited for dmem_ready_i before aborting (>= 2)
//   CNT_W        width of the saturating stall-cycle counter
//
// Ports:
//   clk, rst_n                      clock (rising edge), async active-low reset
//   idex_ins_flag_i                 ID/EX holds a valid instruction
//   idex_reg_we_i/idex_reg_waddr_i  ID/EX writes rd / rd index
//   idex_mtype_i/idex_mem_rw_i      ID/EX memory op / 0=load 1=store
//   id_rs1_re_i/id_rs1_raddr_i      ID reads rs1 / rs1 index
//   id_rs2_re_i/id_rs2_raddr_i      ID reads rs2 / rs2 index
//   ex_jump_flag_i/ex_jump_pc_i     EX taken branch/jump and its target
//   exmem_req_i/dmem_ready_i        data-memory request / completion
//   fc_stall_*_o, fc_flush_*_o      pipeline register hold/bubble controls
//   fc_jump_flag_o/fc_jump_pc_o     PC redirect request and target
//   fc_mem_err_o                    one-cycle pulse on memory wait timeout
//   fc_stall_cnt_o                  saturating count of PC-stall cycles
// ---------------------------------------------------------------------------
module fc_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             idex_ins_flag_i,
    input  logic             idex_reg_we_i,
    input  logic [4:0]       idex_reg_waddr_i,
    input  logic             idex_mtype_i,
    input  logic             idex_mem_rw_i,
    input  logic             id_rs1_re_i,
    input  logic [4:0]       id_rs1_raddr_i,
    input  logic             id_rs2_re_i,
    input  logic [4:0]       id_rs2_raddr_i,
    input  logic             ex_jump_flag_i,
    input  logic [31:0]      ex_jump_pc_i,
    input  logic             exmem_req_i,
    input  logic             dmem_ready_i,
    output logic             fc_stall_pc_o,
    output logic             fc_stall_ifid_o,
    output logic             fc_flush_ifid_o,
    output logic             fc_stall_idex_o,
    output logic             fc_flush_idex_o,
    output logic             fc_stall_exmem_o,
    output logic             fc_jump_flag_o,
    output logic [31:0]      fc_jump_pc_o,
    output logic             fc_mem_err_o,
    output logic [CNT_W-1:0] fc_stall_cnt_o
);

    localparam int TCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(MEM_TIMEOUT);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } fc_state_t;

    fc_state_t         state, state_next;
    logic [TCNT_W-1:0] tcnt, tcnt_next;
    logic              mem_err_next;
    logic [CNT_W-1:0]  stall_cnt;

    logic              mem_miss;
    logic              load_use;

    logic              stall_pc, stall_ifid, flush_ifid;
    logic              stall_idex, flush_idex_raw, stall_exmem;
    logic              jump_flag;
    logic [31:0]       jump_pc;

    // A request that is already ready in its issue cycle completes without
    // any stall; only a not-yet-ready request opens a wait.
    assign mem_miss = exmem_req_i & ~dmem_ready_i;

    // Load in ID/EX whose (non-x0) destination is read by the instruction
    // in ID: the value arrives one cycle too late for forwarding.
    assign load_use = idex_ins_flag_i & idex_mtype_i & ~idex_mem_rw_i &
                      idex_reg_we_i & (idex_reg_waddr_i != 5'd0) &
                      ((id_rs1_re_i & (id_rs1_raddr_i == idex_reg_waddr_i)) |
                       (id_rs2_re_i & (id_rs2_raddr_i == idex_reg_waddr_i)));

    // State, timeout counter, error pulse and stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            tcnt         <= '0;
            fc_mem_err_o <= 1'b0;
            stall_cnt    <= '0;
        end else begin
            state        <= state_next;
            tcnt         <= tcnt_next;
            fc_mem_err_o <= mem_err_next;
            if (fc_stall_pc_o && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // Next state: open a wait on a memory miss, leave it on ready or after
    // MEM_TIMEOUT cycles of waiting (raising the error pulse).
    always_comb begin
        state_next   = state;
        tcnt_next    = tcnt;
        mem_err_next = 1'b0;
        case (state)
            RUN: begin
                if (mem_miss) begin
                    state_next = MEM_WAIT;
                    tcnt_next  = TCNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (dmem_ready_i) begin
                    state_next = RUN;
                    tcnt_next  = '0;
                end else if (tcnt == TCNT_MAX) begin
                    state_next   = RUN;
                    tcnt_next    = '0;
                    mem_err_next = 1'b1;
                end else begin
                    tcnt_next = tcnt + TCNT_W'(1);
                end
            end
            default: begin
                state_next = RUN;
                tcnt_next  = '0;
            end
        endcase
    end

    // Control outputs. The memory wait freezes everything up to EX/MEM, so a
    // jump sitting in EX is held and only taken once the wait ends.
    always_comb begin
        stall_pc       = 1'b0;
        stall_ifid     = 1'b0;
        flush_ifid     = 1'b0;
        stall_idex     = 1'b0;
        flush_idex_raw = 1'b0;
        stall_exmem    = 1'b0;
        jump_flag      = 1'b0;
        jump_pc        = 32'd0;
        case (state)
            RUN: begin
                if (mem_miss) begin
                    stall_pc    = 1'b1;
                    stall_ifid  = 1'b1;
                    stall_idex  = 1'b1;
                    stall_exmem = 1'b1;
                end else if (ex_jump_flag_i) begin
                    jump_flag      = 1'b1;
                    jump_pc        = ex_jump_pc_i;
                    flush_ifid     = 1'b1;
                    flush_idex_raw = 1'b1;
                end else if (load_use) begin
                    stall_pc       = 1'b1;
                    stall_ifid     = 1'b1;
                    flush_idex_raw = 1'b1;
                end
            end
            MEM_WAIT: begin
                stall_pc    = 1'b1;
                stall_ifid  = 1'b1;
                stall_idex  = 1'b1;
                stall_exmem = 1'b1;
            end
            default: ;
        endcase
    end

    // While in reset every control is forced inactive. A hold on ID/EX wins
    // over a bubble, matching how id_ex_reg resolves both.
    assign fc_stall_pc_o    = rst_n & stall_pc;
    assign fc_stall_ifid_o  = rst_n & stall_ifid;
    assign fc_flush_ifid_o  = rst_n & flush_ifid;
    assign fc_stall_idex_o  = rst_n & stall_idex;
    assign fc_flush_idex_o  = rst_n & flush_idex_raw & ~stall_idex;
    assign fc_stall_exmem_o = rst_n & stall_exmem;
    assign fc_jump_flag_o   = rst_n & jump_flag;
    assign fc_jump_pc_o     = rst_n ? jump_pc : 32'd0;
    assign fc_stall_cnt_o   = stall_cnt;

endmodule
